mbc3_cart: RTL and testbench

Cartridge-side memory bank controller: the responder to the console's cartridge bus (`a`, `wr`, `rd`, `cs`, data). It decodes console writes into MBC3 bank, RAM-enable and RTC control registers. It maps console reads and writes onto a flat external ROM and SRAM, and keeps a battery-style real-time clock with a latch snapshot. It sits between the console bus pins and the physical ROM/SRAM models in the simulation/FPGA top.

---
 rtl/mbc3_pkg.sv | 41 ++++
 rtl/mbc3_rtc.sv | 117 +++++++++++
 rtl/mbc3_cart.sv | 104 ++++++++++
 tb/tb_mbc3_cart.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mbc3_pkg.sv
// Shared MBC3 constants: bus region bases, register keys, RTC select codes and time layout.
// No logic of its own; imported by mbc3_cart and mbc3_rtc.
package mbc3_pkg;

    localparam logic [15:0] ROM0_BASE   = 16'h0000;
    localparam logic [15:0] ROMX_BASE   = 16'h4000;
    localparam logic [15:0] RAMEN_BASE  = 16'h0000;
    localparam logic [15:0] BANK_BASE   = 16'h2000;
    localparam logic [15:0] SEL_BASE    = 16'h4000;
    localparam logic [15:0] LATCH_BASE  = 16'h6000;
    localparam logic [15:0] XRAM_BASE   = 16'hA000;

    // Register writes and the external-RAM window decode on 8 KB granules (a[15:13]).
    localparam logic [2:0] RGN_RAMEN = RAMEN_BASE[15:13];
    localparam logic [2:0] RGN_BANK  = BANK_BASE[15:13];
    localparam logic [2:0] RGN_SEL   = SEL_BASE[15:13];
    localparam logic [2:0] RGN_LATCH = LATCH_BASE[15:13];
    localparam logic [2:0] RGN_XRAM  = XRAM_BASE[15:13];

    localparam logic [3:0] RAM_EN_KEY = 4'hA;

    localparam logic [3:0] RTC_SEL_S  = 4'h8;
    localparam logic [3:0] RTC_SEL_M  = 4'h9;
    localparam logic [3:0] RTC_SEL_H  = 4'hA;
    localparam logic [3:0] RTC_SEL_DL = 4'hB;
    localparam logic [3:0] RTC_SEL_DH = 4'hC;

    typedef struct packed {
        logic       carry;
        logic       halt;
        logic [8:0] day;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } rtc_time_t;

    function automatic logic is_rtc_sel(input logic [3:0] sel);
        return (sel >= RTC_SEL_S) && (sel <= RTC_SEL_DH);
    endfunction

endpackage

// File: rtl/mbc3_rtc.sv
// MBC3 real-time clock: prescaler, live S/M/H/day counters, register write port, latch snapshot.
// Writes and latch commit on the clk edge; snapshot read is combinational. No backpressure.
module mbc3_rtc
    import mbc3_pkg::*;
#(
    parameter int CLK_HZ = 4194304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reg_wr,
    input  logic [3:0] sel,
    input  logic [7:0] wdata,
    input  logic       latch_wr,
    output logic [7:0] rdata
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    rtc_time_t     live_q, live_d, snap_q, snap_d, ticked;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    last_q, last_d;
    logic          tick;

    // Out-of-range fields roll over on their own width and do not carry.
    always_comb begin
        ticked = live_q;
        if (live_q.s == 6'd59) begin
            ticked.s = 6'd0;
            if (live_q.m == 6'd59) begin
                ticked.m = 6'd0;
                if (live_q.h == 5'd23) begin
                    ticked.h   = 5'd0;
                    ticked.day = live_q.day + 9'd1;
                    if (live_q.day == 9'd511) begin
                        ticked.carry = 1'b1;
                    end
                end else begin
                    ticked.h = live_q.h + 5'd1;
                end
            end else begin
                ticked.m = live_q.m + 6'd1;
            end
        end else begin
            ticked.s = live_q.s + 6'd1;
        end
    end

    always_comb begin
        pre_d  = pre_q;
        live_d = live_q;
        snap_d = snap_q;
        last_d = last_q;
        tick   = 1'b0;
        if (!live_q.halt) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                tick  = !reg_wr;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
        if (tick) begin
            live_d = ticked;
        end
        if (reg_wr) begin
            case (sel)
                RTC_SEL_S: begin
                    live_d.s = wdata[5:0];
                    pre_d    = '0;
                end
                RTC_SEL_M:  live_d.m        = wdata[5:0];
                RTC_SEL_H:  live_d.h        = wdata[4:0];
                RTC_SEL_DL: live_d.day[7:0] = wdata;
                RTC_SEL_DH: begin
                    live_d.day[8] = wdata[0];
                    live_d.halt   = wdata[6];
                    live_d.carry  = wdata[7];
                end
                default: ;
            endcase
        end
        // Snapshot takes the registered (pre-tick) live value on a 00->01 edge of the latch register.
        if (latch_wr) begin
            last_d = wdata;
            if ((last_q == 8'h00) && (wdata == 8'h01)) begin
                snap_d = live_q;
            end
        end
    end

    always_comb begin
        case (sel)
            RTC_SEL_S:  rdata = {2'b00, snap_q.s};
            RTC_SEL_M:  rdata = {2'b00, snap_q.m};
            RTC_SEL_H:  rdata = {3'b000, snap_q.h};
            RTC_SEL_DL: rdata = snap_q.day[7:0];
            RTC_SEL_DH: rdata = {snap_q.carry, snap_q.halt, 5'b00000, snap_q.day[8]};
            default:    rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
            snap_q <= '0;
            pre_q  <= '0;
            last_q <= 8'hFF;
        end else begin
            live_q <= live_d;
            snap_q <= snap_d;
            pre_q  <= pre_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mbc3_cart.sv
// MBC3 cartridge controller: bank/RAM-enable/select registers, ROM/SRAM address and read-data muxing.
// Register writes commit on the clk edge; addresses, dout and ram_we are combinational. No backpressure.
// RTC and latch are built only when MBC3_RTC_EN is defined.
module mbc3_cart
    import mbc3_pkg::*;
#(
    parameter int CLK_HZ = 4194304
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        wr,
    input  logic        rd,
    input  logic        cs,
    output logic [20:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic [14:0] ram_addr,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  ram_wdata,
    output logic        ram_we
);

    logic [6:0] rom_bank_q, rom_bank_d;
    logic [3:0] sel_q, sel_d;
    logic       ram_en_q, ram_en_d;
    logic [2:0] rgn;
    logic [6:0] eff_bank;
    logic       xram_ok, sel_ram, sel_rtc;
    logic [7:0] rtc_rdata;
    logic       unused_ok;

    assign rgn = a[15:13];

    always_comb begin
        rom_bank_d = rom_bank_q;
        sel_d      = sel_q;
        ram_en_d   = ram_en_q;
        if (wr) begin
            case (rgn)
                RGN_RAMEN: ram_en_d   = (din[3:0] == RAM_EN_KEY);
                RGN_BANK:  rom_bank_d = din[6:0];
                RGN_SEL:   sel_d      = din[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_bank_q <= 7'd1;
            sel_q      <= 4'd0;
            ram_en_q   <= 1'b0;
        end else begin
            rom_bank_q <= rom_bank_d;
            sel_q      <= sel_d;
            ram_en_q   <= ram_en_d;
        end
    end

    // Bank 0 in the switchable window aliases to bank 1.
    assign eff_bank  = (rom_bank_q == 7'd0) ? 7'd1 : rom_bank_q;
    assign rom_addr  = a[14] ? {eff_bank, a[13:0]} : {7'd0, a[13:0]};
    assign ram_addr  = {sel_q[1:0], a[12:0]};
    assign ram_wdata = din;
    assign xram_ok   = (rgn == RGN_XRAM) && cs && ram_en_q;
    assign sel_ram   = (sel_q[3:2] == 2'b00);
    assign ram_we    = wr && xram_ok && sel_ram;

`ifdef MBC3_RTC_EN
    assign sel_rtc = is_rtc_sel(sel_q);

    mbc3_rtc #(
        .CLK_HZ(CLK_HZ)
    ) u_rtc (
        .clk     (clk),
        .rst     (rst),
        .reg_wr  (wr && xram_ok && sel_rtc),
        .sel     (sel_q),
        .wdata   (din),
        .latch_wr(wr && (rgn == RGN_LATCH)),
        .rdata   (rtc_rdata)
    );
`else
    assign sel_rtc   = 1'b0;
    assign rtc_rdata = 8'hFF;
`endif

    always_comb begin
        if (!a[15]) begin
            dout = rom_rdata;
        end else if (xram_ok && sel_ram) begin
            dout = ram_rdata;
        end else if (xram_ok && sel_rtc) begin
            dout = rtc_rdata;
        end else begin
            dout = 8'hFF;
        end
    end

    assign unused_ok = ^{rd, (CLK_HZ == 0)};

endmodule

// File: tb/tb_mbc3_cart.sv
// Directed bench for mbc3_cart: banking, RAM gating, reset, and RTC behaviour when MBC3_RTC_EN is set.
module tb_mbc3_cart;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        cs = 1'b1;
    logic [20:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic [14:0] ram_addr;
    logic [7:0]  ram_rdata;
    logic [7:0]  ram_wdata;
    logic        ram_we;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [0:32767];
    logic        seen_we;
    logic [14:0] seen_ra;
    logic [7:0]  rv;

    mbc3_cart #(.CLK_HZ(16)) dut (
        .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout), .wr(wr), .rd(rd), .cs(cs),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .ram_wdata(ram_wdata), .ram_we(ram_we)
    );

    always #5 clk = ~clk;

    assign rom_rdata = rom_addr[7:0] ^ {1'b0, rom_addr[20:14]};
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; holds the write for one edge, records ram_we/ram_addr seen mid-cycle.
    task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
        a = addr; din = data; wr = 1'b1;
        @(negedge clk);
        seen_we = ram_we;
        seen_ra = ram_addr;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] addr, output logic [7:0] d);
        a = addr; rd = 1'b1;
        #1;
        d = dout;
        rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic latch_rtc();
        bus_wr(16'h6000, 8'h00);
        bus_wr(16'h6000, 8'h01);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        bus_rd(16'h4123, rv);
        check_eq("rst_rom_addr", rom_addr, 21'h004123);
        check_eq("rst_rom_dout", rv, 8'h23 ^ 8'h01);
        bus_rd(16'hA010, rv);
        check_eq("rst_xram_ff", rv, 8'hFF);
        check_eq("rst_ram_we", ram_we, 1'b0);

        // ROM banking
        bus_wr(16'h2000, 8'h00);
        bus_rd(16'h4123, rv);
        check_eq("bank0_alias", rom_addr, 21'h004123);
        bus_wr(16'h2000, 8'h7F);
        bus_rd(16'h4123, rv);
        check_eq("bank7f", rom_addr, 21'h1FC123);
        check_eq("bank7f_dout", rv, 8'h23 ^ 8'h7F);
        bus_wr(16'h3FFF, 8'h85);
        bus_rd(16'h7FFF, rv);
        check_eq("bank05_top", rom_addr, 21'h017FFF);
        bus_rd(16'h0123, rv);
        check_eq("rom0_fixed", rom_addr, 21'h000123);

        // RAM gating
        bus_wr(16'hA010, 8'h5A);
        check_eq("dis_we", seen_we, 1'b0);
        bus_rd(16'hA010, rv);
        check_eq("dis_rd", rv, 8'hFF);
        bus_wr(16'h0000, 8'h0A);
        bus_wr(16'h4000, 8'h02);
        bus_wr(16'hA010, 8'h5A);
        check_eq("en_we", seen_we, 1'b1);
        check_eq("en_ram_addr", seen_ra, 15'h4010);
        bus_rd(16'hA010, rv);
        check_eq("en_readback", rv, 8'h5A);
        cs = 1'b0;
        bus_rd(16'hA010, rv);
        check_eq("nocs_rd", rv, 8'hFF);
        bus_wr(16'hA010, 8'h11);
        check_eq("nocs_we", seen_we, 1'b0);
        cs = 1'b1;
        bus_wr(16'h1000, 8'h0B);
        bus_rd(16'hA010, rv);
        check_eq("badkey_rd", rv, 8'hFF);
        bus_wr(16'h1000, 8'h1A);
        bus_rd(16'hA010, rv);
        check_eq("key1a_rd", rv, 8'h5A);

`ifdef MBC3_RTC_EN
        // Full rollover; latch on the tick edge captures pre-tick values
        bus_wr(16'h4000, 8'h08); bus_wr(16'hA000, 8'h00);
        check_eq("rtc_we_low", seen_we, 1'b0);
        bus_wr(16'h4000, 8'h0C); bus_wr(16'hA000, 8'h01);
        bus_wr(16'h4000, 8'h0B); bus_wr(16'hA000, 8'hFF);
        bus_wr(16'h4000, 8'h0A); bus_wr(16'hA000, 8'h17);
        bus_wr(16'h4000, 8'h09); bus_wr(16'hA000, 8'h3B);
        bus_wr(16'h4000, 8'h08); bus_wr(16'hA000, 8'h3B);
        idle(14);
        latch_rtc();
        bus_rd(16'hA000, rv);
        check_eq("pretick_s", rv, 8'h3B);
        latch_rtc();
        bus_rd(16'hA000, rv);
        check_eq("roll_s", rv, 8'h00);
        bus_wr(16'h4000, 8'h09); bus_rd(16'hA000, rv);
        check_eq("roll_m", rv, 8'h00);
        bus_wr(16'h4000, 8'h0A); bus_rd(16'hA000, rv);
        check_eq("roll_h", rv, 8'h00);
        bus_wr(16'h4000, 8'h0B); bus_rd(16'hA000, rv);
        check_eq("roll_dl", rv, 8'h00);
        bus_wr(16'h4000, 8'h0C); bus_rd(16'hA000, rv);
        check_eq("roll_dh", rv, 8'h80);

        // Latch edge detection
        bus_wr(16'h4000, 8'h08); bus_wr(16'hA000, 8'h0A);
        latch_rtc();
        idle(46);
        bus_rd(16'hA000, rv);
        check_eq("latch_hold", rv, 8'h0A);
        bus_wr(16'h6000, 8'h01);
        bus_rd(16'hA000, rv);
        check_eq("latch_01_again", rv, 8'h0A);
        latch_rtc();
        bus_rd(16'hA000, rv);
        check_eq("latch_plus3", rv, 8'h0D);

        // Halt
        bus_wr(16'hA000, 8'h05);
        bus_wr(16'h4000, 8'h0C); bus_wr(16'hA000, 8'h40);
        idle(40);
        bus_wr(16'h4000, 8'h08);
        latch_rtc();
        bus_rd(16'hA000, rv);
        check_eq("halt_s", rv, 8'h05);

        // Out-of-range seconds wrap without carry
        bus_wr(16'h4000, 8'h0C); bus_wr(16'hA000, 8'h00);
        bus_wr(16'h4000, 8'h09); bus_wr(16'hA000, 8'h07);
        bus_wr(16'h4000, 8'h08); bus_wr(16'hA000, 8'h3F);
        idle(16);
        latch_rtc();
        bus_rd(16'hA000, rv);
        check_eq("s63_wrap", rv, 8'h00);
        bus_wr(16'h4000, 8'h09); bus_rd(16'hA000, rv);
        check_eq("s63_m_same", rv, 8'h07);

        // RTC write on the tick edge drops the tick
        bus_wr(16'h4000, 8'h08); bus_wr(16'hA000, 8'h14);
        bus_wr(16'h4000, 8'h09);
        idle(14);
        bus_wr(16'hA000, 8'h1E);
        latch_rtc();
        bus_rd(16'hA000, rv);
        check_eq("coll_m", rv, 8'h1E);
        bus_wr(16'h4000, 8'h08); bus_rd(16'hA000, rv);
        check_eq("coll_s_dropped", rv, 8'h14);
`else
        bus_wr(16'h4000, 8'h08);
        bus_rd(16'hA000, rv);
        check_eq("nortc_rd", rv, 8'hFF);
        bus_wr(16'hA000, 8'h33);
        check_eq("nortc_we", seen_we, 1'b0);
`endif

        // Asynchronous reset between edges
        bus_wr(16'h4000, 8'h00);
        a = 16'hA010; din = 8'h77; wr = 1'b1;
        #1;
        check_eq("pre_rst_we", ram_we, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_we", ram_we, 1'b0);
        check_eq("rst_async_dout", dout, 8'hFF);
        wr = 1'b0;
        bus_rd(16'h4123, rv);
        check_eq("rst_async_bank", rom_addr, 21'h004123);
        rst = 1'b0;
        idle(1);
        bus_wr(16'h0000, 8'h0A);
        bus_rd(16'hA010, rv);
        check_eq("rst_sel0_addr", ram_addr, 15'h0010);
        bus_wr(16'h4000, 8'h08);
`ifdef MBC3_RTC_EN
        bus_rd(16'hA000, rv);
        check_eq("rst_snap_zero", rv, 8'h00);
        idle(11);
        latch_rtc();
        bus_rd(16'hA000, rv);
        check_eq("rst_pretick", rv, 8'h00);
        latch_rtc();
        bus_rd(16'hA000, rv);
        check_eq("rst_first_tick", rv, 8'h01);
`else
        bus_rd(16'hA000, rv);
        check_eq("nortc_rst_rd", rv, 8'hFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
